// File: rtl/sdp_ram_rd_if.sv
// sdp_ram_rd_if: AXI4 read slave serving INCR bursts from the read port of a
// simple-dual-port RAM. The RAM's fixed read latency is absorbed by a small
// output FIFO. Issue credit is sized so that data already requested always
// has room, which lets RREADY backpressure stall the burst without losing beats.
module sdp_ram_rd_if #(
  parameter int DW          = 512,
  parameter int DD          = 16384,
  parameter int RAM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [$clog2(DD)-1:0]          addrb,
  output logic                           rd_en,
  input  logic [DW-1:0]                  dob,
  output logic                           last_word_read,
  input  logic [$clog2(DD*(DW/8))-1:0]   S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  input  logic [3:0]                     S_AXI_ARID,
  input  logic [7:0]                     S_AXI_ARLEN,
  input  logic [2:0]                     S_AXI_ARSIZE,
  input  logic [1:0]                     S_AXI_ARBURST,
  input  logic                           S_AXI_ARLOCK,
  input  logic [3:0]                     S_AXI_ARCACHE,
  input  logic [3:0]                     S_AXI_ARQOS,
  input  logic [2:0]                     S_AXI_ARPROT,
  output logic                           S_AXI_ARREADY,
  output logic [DW-1:0]                  S_AXI_RDATA,
  output logic [3:0]                     S_AXI_RID,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RLAST,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY
);

  localparam int AW         = $clog2(DD);
  localparam int BW         = $clog2(DD*(DW/8));
  localparam int OFS        = $clog2(DW/8);
  localparam int FIFO_DEPTH = RAM_LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int SW         = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t          r_state;
  logic            r_arready;
  logic [AW-1:0]   r_addr;
  logic [3:0]      r_id;
  logic [8:0]      r_issue_left;
  logic [8:0]      r_beats_left;

  logic [RAM_LATENCY-1:0] r_vld;
  logic [DW-1:0]   r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_inflight;
  logic [SW-1:0]   w_occupied;
  logic            w_credit;
  logic            w_rd_en;
  logic            w_push;
  logic            w_pop;
  logic            w_rvalid;
  logic            w_rlast;
  logic            w_ar_hs;
  logic            w_unused;

  // Advance a FIFO pointer, wrapping at the (possibly non power-of-2) depth.
  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  assign w_occupied = SW'(r_count) + SW'(w_inflight);
  assign w_credit   = w_occupied < SW'(FIFO_DEPTH);
  assign w_rd_en    = (r_state == S_ISSUE) && w_credit;
  assign w_push     = r_vld[RAM_LATENCY-1];
  assign w_rvalid   = (r_count != '0);
  assign w_pop      = w_rvalid && S_AXI_RREADY;
  assign w_rlast    = w_rvalid && (r_beats_left == 9'd1);
  assign w_ar_hs    = S_AXI_ARVALID && r_arready;

  assign rd_en          = w_rd_en;
  assign addrb          = r_addr;
  assign last_word_read = w_rd_en && (r_addr == AW'(DD - 1));
  assign S_AXI_ARREADY  = r_arready;
  assign S_AXI_RVALID   = w_rvalid;
  assign S_AXI_RDATA    = r_fifo_mem[r_rd_ptr];
  assign S_AXI_RID      = r_id;
  assign S_AXI_RRESP    = 2'b00;
  assign S_AXI_RLAST    = w_rlast;

  // Burst attributes the fabric may drive but this slave does not interpret.
  assign w_unused = ^{S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE,
                      S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARADDR};

  // Burst control FSM: accept one AR, issue all reads, wait for the RLAST handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_arready    <= 1'b0;
      r_issue_left <= '0;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready    <= 1'b0;
            r_state      <= S_ISSUE;
            r_issue_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
            r_beats_left <= {1'b0, S_AXI_ARLEN} + 9'd1;
          end
        end
        S_ISSUE: begin
          if (w_rd_en && (r_issue_left == 9'd1)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_rlast) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_arready <= 1'b0;
        end
      endcase
      if (w_rd_en) begin
        r_issue_left <= r_issue_left - 9'd1;
      end
      if (w_pop) begin
        r_beats_left <= r_beats_left - 9'd1;
      end
    end
  end

  // Word address and ID: loaded on AR acceptance, address steps per issued read.
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_addr <= S_AXI_ARADDR[BW-1:OFS];
      r_id   <= S_AXI_ARID;
    end else if (w_rd_en) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  // RAM latency tracker: one valid bit per read, shifting in step with the RAM pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_en;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output FIFO storage: capture RAM data when its read reaches the end of the pipeline.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= dob;
    end
  end

endmodule

// File: tb/tb_sdp_ram_rd_if.sv
// Directed bench for sdp_ram_rd_if with DW=32, DD=256, RAM_LATENCY=1.
// The RAM model returns 32'hDA7A_0000 + word index one cycle after addrb.
module tb_sdp_ram_rd_if;

  localparam int DW  = 32;
  localparam int DD  = 256;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addrb;
  logic        rd_en;
  logic [31:0] dob;
  logic        last_word_read;
  logic [9:0]  ARADDR;
  logic        ARVALID;
  logic [3:0]  ARID;
  logic [7:0]  ARLEN;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [3:0]  RID;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sdp_ram_rd_if #(.DW(DW), .DD(DD), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .addrb(addrb), .rd_en(rd_en), .dob(dob),
    .last_word_read(last_word_read),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARID(ARID),
    .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(3'd2), .S_AXI_ARBURST(2'd1),
    .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARPROT(3'd0), .S_AXI_ARREADY(ARREADY), .S_AXI_RDATA(RDATA),
    .S_AXI_RID(RID), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dob <= 32'hDA7A_0000 + {24'd0, addrb};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an AR and hold it until accepted; t = handshake cycle, returns in t+1.
  task automatic send_ar(input logic [9:0] addr, input logic [7:0] len,
                         input logic [3:0] id, output int t);
    ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1; t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      if (ARREADY) t = cyc;
      tick();
    end
    ARVALID = 1'b0;
    chk("ar_accepted", 64'(t >= 0), 64'd1);
  endtask

  initial begin
    int t, nb, nlwr, first_c, last_c, ni, lwr_idx, x, t1, t2, nhs;
    logic [7:0]  lwr_addr;
    logic [31:0] expw;
    logic        prev_v, prev_r, prev_l, hs, beat;
    logic [31:0] prev_d;
    logic [31:0] exp4 [4];
    logic [3:0]  rid_q [$];
    logic [31:0] dat_q [$];

    reset = 1'b1; ARADDR = '0; ARVALID = 1'b0; ARID = '0; ARLEN = '0; RREADY = 1'b0;
    repeat (3) tick();
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_lwr", 64'(last_word_read), 64'd0);
    reset = 1'b0;
    tick();
    chk("arready_after_reset", 64'(ARREADY), 64'd1);

    // Single beat from byte address 0x14 (word 5), ARID 5.
    RREADY = 1'b1;
    send_ar(10'h014, 8'd0, 4'd5, t);
    chk("t1_rd_en", 64'(rd_en), 64'd1);
    chk("t1_addrb", 64'(addrb), 64'd5);
    chk("t1_arready_low", 64'(ARREADY), 64'd0);
    tick();
    chk("t1_rvalid_t2", 64'(RVALID), 64'd0);
    tick();
    chk("t1_rvalid_t3", 64'(RVALID), 64'd1);
    chk("t1_rdata", 64'(RDATA), 64'h0000_0000_DA7A_0005);
    chk("t1_rid", 64'(RID), 64'd5);
    chk("t1_rlast", 64'(RLAST), 64'd1);
    chk("t1_rresp", 64'(RRESP), 64'd0);
    tick();
    chk("t1_rvalid_after", 64'(RVALID), 64'd0);
    chk("t1_arready_back", 64'(ARREADY), 64'd1);

    // 256-beat burst from word 0 with RREADY held high.
    send_ar(10'h000, 8'd255, 4'd3, t);
    nb = 0; nlwr = 0; first_c = -1; last_c = -1;
    for (int k = 0; k < 300; k++) begin
      if (last_word_read) nlwr++;
      if (RVALID && RREADY) begin
        expw = 32'hDA7A_0000 + 32'(nb);
        if (nb == 0) first_c = cyc;
        last_c = cyc;
        chk("t2_rdata", 64'(RDATA), 64'(expw));
        chk("t2_rlast", 64'(RLAST), 64'(nb == 255));
        nb++;
      end
      tick();
    end
    chk("t2_beats", 64'(nb), 64'd256);
    chk("t2_first_latency", 64'(first_c - t), 64'd3);
    chk("t2_no_bubbles", 64'(last_c - first_c), 64'd255);
    chk("t2_lwr_pulses", 64'(nlwr), 64'd1);
    chk("t2_arready", 64'(ARREADY), 64'd1);

    // Same burst with RREADY high about 30% of cycles.
    RREADY = 1'b0;
    send_ar(10'h000, 8'd255, 4'd4, t);
    nb = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int k = 0; k < 4000 && nb < 256; k++) begin
      RREADY = ($urandom_range(0, 9) < 3);
      if (prev_v && !prev_r) begin
        chk("t3_stall_rvalid", 64'(RVALID), 64'd1);
        chk("t3_stall_rdata", 64'(RDATA), 64'(prev_d));
        chk("t3_stall_rlast", 64'(RLAST), 64'(prev_l));
      end
      if (RVALID && RREADY) begin
        expw = 32'hDA7A_0000 + 32'(nb);
        chk("t3_rdata", 64'(RDATA), 64'(expw));
        chk("t3_rid", 64'(RID), 64'd4);
        chk("t3_rlast", 64'(RLAST), 64'(nb == 255));
        nb++;
      end
      prev_v = RVALID; prev_r = RREADY; prev_d = RDATA; prev_l = RLAST;
      tick();
    end
    chk("t3_beats", 64'(nb), 64'd256);
    RREADY = 1'b1;
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      if (RVALID) nb++;
      tick();
    end
    chk("t3_no_extra_beat", 64'(nb), 64'd0);
    chk("t3_arready", 64'(ARREADY), 64'd1);

    // Wrap: start word 254, 4 beats -> 254, 255, 0, 1.
    exp4[0] = 32'hDA7A_00FE; exp4[1] = 32'hDA7A_00FF;
    exp4[2] = 32'hDA7A_0000; exp4[3] = 32'hDA7A_0001;
    send_ar(10'h3F8, 8'd3, 4'd6, t);
    nb = 0; ni = 0; nlwr = 0; lwr_idx = -1; lwr_addr = '0;
    for (int k = 0; k < 15; k++) begin
      if (last_word_read) begin
        nlwr++; lwr_idx = ni; lwr_addr = addrb;
      end
      if (rd_en) ni++;
      if (RVALID && RREADY) begin
        if (nb < 4) chk("t4_rdata", 64'(RDATA), 64'(exp4[nb]));
        chk("t4_rlast", 64'(RLAST), 64'(nb == 3));
        nb++;
      end
      tick();
    end
    chk("t4_beats", 64'(nb), 64'd4);
    chk("t4_issues", 64'(ni), 64'd4);
    chk("t4_lwr_pulses", 64'(nlwr), 64'd1);
    chk("t4_lwr_issue_idx", 64'(lwr_idx), 64'd1);
    chk("t4_lwr_addr", 64'(lwr_addr), 64'd255);

    // Reset mid-burst with RREADY low, then a clean 1-beat read of word 7.
    RREADY = 1'b0;
    send_ar(10'h020, 8'd7, 4'd9, t);
    tick(); tick(); tick(); tick();
    chk("t5_rvalid_before_reset", 64'(RVALID), 64'd1);
    chk("t5_rdata_head", 64'(RDATA), 64'h0000_0000_DA7A_0008);
    reset = 1'b1;
    tick();
    chk("t5_rvalid_reset", 64'(RVALID), 64'd0);
    chk("t5_arready_reset", 64'(ARREADY), 64'd0);
    reset = 1'b0;
    tick();
    chk("t5_arready_rise", 64'(ARREADY), 64'd1);
    chk("t5_rvalid_clear", 64'(RVALID), 64'd0);
    RREADY = 1'b1;
    send_ar(10'h01C, 8'd0, 4'd10, t);
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      if (RVALID && RREADY) begin
        chk("t5_rdata", 64'(RDATA), 64'h0000_0000_DA7A_0007);
        chk("t5_rid", 64'(RID), 64'd10);
        chk("t5_rlast", 64'(RLAST), 64'd1);
        nb++;
      end
      tick();
    end
    chk("t5_beats", 64'(nb), 64'd1);

    // Back-to-back ARs with ARVALID held: ID1 2 beats from word 10, ID2 1 beat from word 20.
    ARADDR = 10'h028; ARID = 4'd1; ARLEN = 8'd1; ARVALID = 1'b1;
    x = -1; t1 = -1; t2 = -1; nhs = 0;
    for (int k = 0; k < 40; k++) begin
      hs = ARVALID && ARREADY;
      beat = RVALID && RREADY;
      if (beat) begin
        rid_q.push_back(RID);
        dat_q.push_back(RDATA);
        if (RLAST && x < 0) x = cyc;
      end
      if (hs) begin
        nhs++;
        if (nhs == 1) t1 = cyc; else t2 = cyc;
      end
      tick();
      if (hs && nhs == 1) begin
        ARADDR = 10'h050; ARID = 4'd2; ARLEN = 8'd0;
      end else if (hs) begin
        ARVALID = 1'b0;
      end
    end
    ARVALID = 1'b0;
    chk("t6_beats", 64'(rid_q.size()), 64'd3);
    if (rid_q.size() == 3) begin
      chk("t6_rid0", 64'(rid_q[0]), 64'd1);
      chk("t6_rid1", 64'(rid_q[1]), 64'd1);
      chk("t6_rid2", 64'(rid_q[2]), 64'd2);
      chk("t6_data0", 64'(dat_q[0]), 64'h0000_0000_DA7A_000A);
      chk("t6_data1", 64'(dat_q[1]), 64'h0000_0000_DA7A_000B);
      chk("t6_data2", 64'(dat_q[2]), 64'h0000_0000_DA7A_0014);
    end
    chk("t6_first_rlast", 64'(x - t1), 64'd4);
    chk("t6_second_ar", 64'(t2 - x), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_rd_if.md
# sdp_ram_rd_if

AXI4 read-side slave that serves burst reads from the read port of a simple-dual-port RAM. It sits alongside the RAM's AXI write interface and drives the RAM's `addrb` port. Host software can then read back any RAM content over the same AXI fabric. It absorbs the RAM's fixed read latency and honours RREADY backpressure without losing or duplicating beats.

## Interface
- `DW`, 512: data width in bits, a power of 2 and at least 8.
- `DD`, 16384: RAM depth in words, a power of 2.
- `RAM_LATENCY`, 1: cycles from `addrb` to valid `dob`; legal range 1..3.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addrb`  out  $clog2(DD)  RAM read address.
- `rd_en`  out  1  high in every cycle a RAM read is issued.
- `dob`  in  DW  RAM read data, valid RAM_LATENCY cycles after the matching `rd_en`.
- `last_word_read`  out  1  single-cycle strobe when a read of address DD-1 is issued.
- `S_AXI_ARADDR`  in  $clog2(DD*(DW/8))  byte address.
- `S_AXI_ARVALID`  in  1.
- `S_AXI_ARID`  in  4.
- `S_AXI_ARLEN`  in  8.
- `S_AXI_ARSIZE`, `S_AXI_ARBURST`, `S_AXI_ARLOCK`, `S_AXI_ARCACHE`, `S_AXI_ARQOS`, `S_AXI_ARPROT`  in  3/2/1/4/4/3  accepted and ignored.
- `S_AXI_ARREADY`  out  1.
- `S_AXI_RDATA`  out  DW.
- `S_AXI_RID`  out  4  echoes the ARID of the current burst.
- `S_AXI_RRESP`  out  2  constant 0 (OKAY).
- `S_AXI_RLAST`  out  1.
- `S_AXI_RVALID`  out  1.
- `S_AXI_RREADY`  in  1.

## Operation
- Every burst is treated as INCR and full-width. Start word = ARADDR >> $clog2(DW/8); the low byte-offset bits are ignored. Beat count = ARLEN+1, so 1..256 beats.
- The word address increments by 1 per issued read. It wraps modulo DD, so DD-1 is followed by 0.
- Only one burst is outstanding at a time. ARREADY is high only in IDLE.
- FSM states:
  - IDLE: ARREADY=1. On an AR handshake, latch the start address, ARID and the beat count, drop ARREADY, and go to ISSUE.
  - ISSUE: assert `rd_en` with `addrb` = the current address whenever credit is available. Credit exists when (output FIFO occupancy + reads in flight) < FIFO_DEPTH. Once all reads are issued, go to DRAIN.
  - DRAIN: wait for the RLAST handshake, then go to IDLE with ARREADY=1 in the next cycle.
- Output FIFO:
  - FIFO_DEPTH = RAM_LATENCY+2.
  - `dob` is pushed RAM_LATENCY cycles after each `rd_en`, using a shift register of valid bits.
  - RVALID = FIFO not empty; RDATA = FIFO head.
  - The FIFO pops on RVALID & RREADY.
- RLAST is high with the head beat when that beat is the final beat of the burst, tracked by a beat-out counter. RLAST is never high when RVALID is low.
- The credit rule guarantees the FIFO never overflows. Push and pop in the same cycle leave occupancy unchanged.
- `last_word_read` = `rd_en` & (`addrb` == DD-1).

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, `rd_en`=0, `last_word_read`=0, FSM=IDLE, FIFO empty, in-flight valid bits cleared.
- ARREADY rises in the first cycle after `reset` deasserts.
- With the AR handshake in cycle T:
  - the first `rd_en` is in cycle T+1;
  - the first RVALID is in cycle T+2+RAM_LATENCY (T+3 for latency 1).
- With RREADY held high, throughput is one beat per cycle with no bubbles for any burst length.
- With RLAST accepted in cycle X, ARREADY=1 in cycle X+1.
- RVALID, once high, stays high with RDATA, RID and RLAST stable until the handshake.
- Reset asserted mid-burst:
  - the next cycle shows RVALID=0 and ARREADY=0;
  - in-flight RAM data is discarded;
  - no stale beat appears after reset.

## Test plan
- DD=16, DW=32, ARADDR=0x14, ARLEN=0, ARID=5, RREADY=1 -> exactly one beat carrying RAM word 5, RID=5, RLAST=1, first RVALID at T+3, ARREADY back high one cycle after the beat.
- ARADDR=0, ARLEN=255 (DD=256), RREADY=1 -> 256 beats on consecutive cycles carrying words 0..255, RLAST only on beat 256, `last_word_read` pulses once.
- Same 256-beat burst with RREADY random 30% duty -> every word delivered exactly once and in order, no FIFO overflow, RDATA stable while stalled.
- DD=16, start word 14, ARLEN=3 -> data from words 14, 15, 0, 1; `last_word_read` pulses when word 15 is issued.
- Reset asserted on beat 3 of an 8-beat burst with RREADY=0 -> RVALID=0 next cycle; then a new 1-beat read of word 7 returns only word 7.
- Two back-to-back ARs (ARID 1, ARLEN 1; then ARID 2, ARLEN 0) with ARVALID held -> second AR accepted the cycle after the first RLAST handshake, RIDs 1,1,2 in order.
